// File: rtl/instruction_cache.sv
// Single-block instruction cache: fills ISA_DEPTH words from DDR one word at a time, then serves instruction fetches.
// Optional build macro INS_CACHE_PARITY_EN adds a per-word even-parity bit and a par_err output.
module instruction_cache #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int INS_WIDTH       = 64,
  parameter logic [DDR_ADDR_WIDTH-1:0] DDR_INS_BASE = 28'h0100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      ins_cache_rdy,
  output logic [3:0]                st_cur_ins_cache,
  output logic [9:0]                load_times,
  output logic [INS_WIDTH-1:0]      ins_out,
  output logic                      ins_out_valid,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      ddr_rd_ack,
  input  logic [INS_WIDTH-1:0]      ddr_rd_data,
  input  logic                      ddr_rd_data_valid
`ifdef INS_CACHE_PARITY_EN
  ,
  output logic                      par_err
`endif
);

  typedef enum logic [3:0] {
    START     = 4'd1,
    LOAD_INS  = 4'd2,
    SENT_INS  = 4'd3,
    LOAD_WAIT = 4'd4
  } state_t;

  localparam int OFF_W = $clog2(ISA_DEPTH);
  localparam int BLK_W = ADDR_WIDTH_MEM - OFF_W;
  localparam logic [OFF_W-1:0]          LAST_I  = OFF_W'(ISA_DEPTH - 1);
  localparam logic [ADDR_WIDTH_MEM-1:0] TOTAL_A = ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH);

  state_t               state;
  logic [BLK_W-1:0]     blk;
  logic [OFF_W-1:0]     i;
  logic [INS_WIDTH-1:0] mem [ISA_DEPTH];
`ifdef INS_CACHE_PARITY_EN
  logic                 mem_par [ISA_DEPTH];
`endif

  logic [BLK_W-1:0] addr_blk;
  logic [OFF_W-1:0] addr_off;
  logic             in_range;
  logic             blk_hit;

  assign addr_blk         = addr_ins[ADDR_WIDTH_MEM-1:OFF_W];
  assign addr_off         = addr_ins[OFF_W-1:0];
  assign in_range         = addr_ins < TOTAL_A;
  assign blk_hit          = (10'(addr_blk) + 10'd1) == load_times;
  assign st_cur_ins_cache = state;

  function automatic logic [DDR_ADDR_WIDTH-1:0] word_addr(input logic [BLK_W-1:0] b,
                                                          input logic [OFF_W-1:0] w);
    return DDR_INS_BASE + DDR_ADDR_WIDTH'({b, w, 3'b000});
  endfunction

  // Fill storage carries no reset; only load_times says whether it holds anything.
  always_ff @(posedge clk) begin
    if (state == LOAD_WAIT && ddr_rd_data_valid) begin
      mem[i] <= ddr_rd_data;
`ifdef INS_CACHE_PARITY_EN
      mem_par[i] <= ^ddr_rd_data;
`endif
    end
  end

  // DDR handshake: ddr_rd_req/ddr_rd_addr stay stable from LOAD_INS entry until ddr_rd_ack is
  // sampled high; req drops the next cycle, and ddr_rd_data_valid is honoured only in LOAD_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= START;
      blk           <= '0;
      i             <= '0;
      load_times    <= '0;
      ins_cache_rdy <= 1'b0;
      ins_out       <= '0;
      ins_out_valid <= 1'b0;
      ddr_rd_req    <= 1'b0;
      ddr_rd_addr   <= '0;
`ifdef INS_CACHE_PARITY_EN
      par_err       <= 1'b0;
`endif
    end else begin
`ifdef INS_CACHE_PARITY_EN
      par_err <= 1'b0;
`endif
      case (state)
        START: begin
          state         <= LOAD_INS;
          blk           <= addr_blk;
          i             <= '0;
          ins_cache_rdy <= 1'b0;
          ddr_rd_req    <= 1'b1;
          ddr_rd_addr   <= word_addr(addr_blk, {OFF_W{1'b0}});
        end
        LOAD_INS: begin
          if (ddr_rd_ack) begin
            ddr_rd_req <= 1'b0;
            state      <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (ddr_rd_data_valid) begin
            if (i == LAST_I) begin
              state         <= SENT_INS;
              load_times    <= 10'(blk) + 10'd1;
              ins_cache_rdy <= 1'b1;
            end else begin
              i           <= i + OFF_W'(1);
              state       <= LOAD_INS;
              ddr_rd_req  <= 1'b1;
              ddr_rd_addr <= word_addr(blk, i + OFF_W'(1));
            end
          end
        end
        SENT_INS: begin
          if (in_range && blk_hit) begin
`ifdef INS_CACHE_PARITY_EN
            if ((^mem[addr_off]) != mem_par[addr_off]) begin
              ins_out_valid <= 1'b0;
              par_err       <= 1'b1;
            end else begin
              ins_out       <= mem[addr_off];
              ins_out_valid <= 1'b1;
            end
`else
            ins_out       <= mem[addr_off];
            ins_out_valid <= 1'b1;
`endif
          end else if (in_range) begin
            // Block switch: the new block is fixed here; later addr_ins changes wait until SENT_INS.
            state         <= LOAD_INS;
            blk           <= addr_blk;
            i             <= '0;
            ins_out_valid <= 1'b0;
            ins_cache_rdy <= 1'b0;
            ddr_rd_req    <= 1'b1;
            ddr_rd_addr   <= word_addr(addr_blk, {OFF_W{1'b0}});
          end else begin
            ins_out_valid <= 1'b0;
          end
        end
        default: begin
          state         <= START;
          ins_out_valid <= 1'b0;
          ins_cache_rdy <= 1'b0;
          ddr_rd_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized bench for instruction_cache: a DDR responder with an expected-address scoreboard and
// a block-level cache model (resident block, DDR content function) predicting every fetch.
module tb_instruction_cache;

  localparam int          DEPTH = 64;
  localparam int          TOTAL = 128;
  localparam logic [27:0] BASE  = 28'h0100000;

  logic        clk;
  logic        rst;
  logic [15:0] addr_ins;
  logic        ins_cache_rdy;
  logic [3:0]  st_cur_ins_cache;
  logic [9:0]  load_times;
  logic [63:0] ins_out;
  logic        ins_out_valid;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic        ddr_rd_ack;
  logic [63:0] ddr_rd_data;
  logic        ddr_rd_data_valid;
`ifdef INS_CACHE_PARITY_EN
  logic        par_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [27:0] exp_q[$];
  int          ack_cnt   = 0;
  bit          fixed_lat = 1'b1;
  int          resident  = -1;
  logic [63:0] last_ins  = '0;

  instruction_cache dut (
    .clk               (clk),
    .rst               (rst),
    .addr_ins          (addr_ins),
    .ins_cache_rdy     (ins_cache_rdy),
    .st_cur_ins_cache  (st_cur_ins_cache),
    .load_times        (load_times),
    .ins_out           (ins_out),
    .ins_out_valid     (ins_out_valid),
    .ddr_rd_req        (ddr_rd_req),
    .ddr_rd_addr       (ddr_rd_addr),
    .ddr_rd_ack        (ddr_rd_ack),
    .ddr_rd_data       (ddr_rd_data),
    .ddr_rd_data_valid (ddr_rd_data_valid)
`ifdef INS_CACHE_PARITY_EN
    ,
    .par_err           (par_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DDR content as seen by the bench: a fixed hash of the byte address.
  function automatic logic [63:0] ddr_data(input logic [27:0] a);
    logic [31:0] h;
    h = {4'h0, a} * 32'h9E3779B1;
    return {h ^ 32'h5A5A1234, 4'h0, a};
  endfunction

  function automatic logic [27:0] word_ddr(input int w);
    return BASE + 28'(w * 8);
  endfunction

  task automatic push_block(input int b);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(word_ddr(b * DEPTH + k));
  endtask

  task automatic wait_sent(input string tag);
    int n;
    n = 0;
    while (st_cur_ins_cache != 4'd3 && n < 5000) begin
      step();
      n++;
    end
    check(tag, 64'(n < 5000), 64'd1);
  endtask

  // ---------------- DDR responder + scoreboard ----------------
  initial begin
    int          n;
    logic [27:0] a;
    logic [27:0] e;
    ddr_rd_ack        = 1'b0;
    ddr_rd_data_valid = 1'b0;
    ddr_rd_data       = '0;
    forever begin
      step();
      if (rst && ddr_rd_req) begin
        n = fixed_lat ? 0 : int'($urandom_range(0, 2));
        while (n > 0 && rst) begin step(); n--; end
        if (rst) begin
          a = ddr_rd_addr;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = '1;
          check("rd_addr", 64'(a), 64'(e));
          ddr_rd_ack = 1'b1;
          step();
          ddr_rd_ack = 1'b0;
          ack_cnt++;
          n = fixed_lat ? 1 : int'($urandom_range(0, 3));
          while (n > 0 && rst) begin step(); n--; end
          if (rst) begin
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = ddr_data(a);
            step();
            ddr_rd_data_valid = 1'b0;
          end
        end
      end
    end
  end

  // One fetch from the PC, predicted from the resident block.
  task automatic do_access(input int a);
    logic [63:0] exp;
    if (a < TOTAL && a / DEPTH != resident) push_block(a / DEPTH);
    addr_ins = 16'(a);
    step();
    if (a < TOTAL && a / DEPTH == resident) begin
      exp = ddr_data(word_ddr(a));
      check("hit_data", ins_out, exp);
      check("hit_valid", 64'(ins_out_valid), 64'd1);
      last_ins = exp;
    end else if (a < TOTAL) begin
      check("miss_rdy", 64'(ins_cache_rdy), 64'd0);
      check("miss_state", 64'(st_cur_ins_cache), 64'd2);
      wait_sent("miss_done");
      check("miss_sb_empty", 64'(exp_q.size()), 64'd0);
      resident = a / DEPTH;
      check("miss_load_times", 64'(load_times), 64'(resident + 1));
      check("miss_rdy_after", 64'(ins_cache_rdy), 64'd1);
      step();
      exp = ddr_data(word_ddr(a));
      check("miss_data", ins_out, exp);
      check("miss_valid", 64'(ins_out_valid), 64'd1);
      last_ins = exp;
    end else begin
      check("oor_valid", 64'(ins_out_valid), 64'd0);
      check("oor_state", 64'(st_cur_ins_cache), 64'd3);
      check("oor_req", 64'(ddr_rd_req), 64'd0);
      check("oor_hold", ins_out, last_ins);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(st_cur_ins_cache), 64'd1);
    check({tag, "_load_times"}, 64'(load_times), 64'd0);
    check({tag, "_rdy"}, 64'(ins_cache_rdy), 64'd0);
    check({tag, "_ins_out"}, ins_out, 64'd0);
    check({tag, "_valid"}, 64'(ins_out_valid), 64'd0);
    check({tag, "_req"}, 64'(ddr_rd_req), 64'd0);
    check({tag, "_addr"}, 64'(ddr_rd_addr), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a;
    int r;
    int n;
    int tb_blk;
    int ack0;
    rst      = 1'b0;
    addr_ins = '0;
    repeat (3) step();
    check_reset_outputs("reset");

    // First fill of block 0 with fixed DDR latency.
    push_block(0);
    rst = 1'b1;
    step();
    wait_sent("load0_done");
    check("load0_sb_empty", 64'(exp_q.size()), 64'd0);
    check("load0_acks", 64'(ack_cnt), 64'd64);
    check("load0_load_times", 64'(load_times), 64'd1);
    check("load0_state", 64'(st_cur_ins_cache), 64'd3);
    check("load0_rdy", 64'(ins_cache_rdy), 64'd1);
    resident  = 0;
    fixed_lat = 1'b0;

    do_access(5);
    for (int k = 0; k < 12; k++) do_access(int'($urandom_range(0, 63)));

`ifdef INS_CACHE_PARITY_EN
    dut.mem_par[7] = ~dut.mem_par[7];
    addr_ins = 16'd7;
    step();
    check("par_err_pulse", 64'(par_err), 64'd1);
    check("par_valid", 64'(ins_out_valid), 64'd0);
    check("par_hold", ins_out, last_ins);
    do_access(8);
    check("par_err_clear", 64'(par_err), 64'd0);
    dut.mem_par[7] = ~dut.mem_par[7];
`endif

    // Sequential step across the block boundary.
    do_access(63);
    do_access(64);
    do_access(65);

    // PC jump marker address held for ten cycles.
    addr_ins = 16'h8000;
    for (int k = 0; k < 10; k++) begin
      step();
      check("jump_req", 64'(ddr_rd_req), 64'd0);
      check("jump_valid", 64'(ins_out_valid), 64'd0);
      check("jump_state", 64'(st_cur_ins_cache), 64'd3);
    end
    check("jump_hold", ins_out, last_ins);

    // Randomized mix of hits, block switches and out-of-range fetches.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) a = resident * DEPTH + int'($urandom_range(0, 63));
      else if (r < 8) a = int'($urandom_range(0, TOTAL - 1));
      else a = int'($urandom_range(TOTAL, 65535));
      do_access(a);
    end

    // Reset in the middle of a fill; the refill follows addr_ins at reset release.
    a = (resident == 0) ? 70 : 10;
    push_block(a / DEPTH);
    ack0 = ack_cnt;
    addr_ins = 16'(a);
    n = 0;
    while (ack_cnt < ack0 + 31 && n < 5000) begin step(); n++; end
    check("midload_reached", 64'(n < 5000), 64'd1);
    rst = 1'b0;
    tb_blk = int'($urandom_range(0, 1));
    addr_ins = 16'(tb_blk * DEPTH + 3);
    exp_q.delete();
    resident = -1;
    last_ins = '0;
    step();
    check_reset_outputs("midload_reset");
    step();
    push_block(tb_blk);
    rst = 1'b1;
    step();
    wait_sent("reload_done");
    check("reload_sb_empty", 64'(exp_q.size()), 64'd0);
    check("reload_load_times", 64'(load_times), 64'(tb_blk + 1));
    resident = tb_blk;
    step();
    check("reload_data", ins_out, ddr_data(word_ddr(tb_blk * DEPTH + 3)));
    check("reload_valid", 64'(ins_out_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
